// File: rtl/sdpram_pkg.sv
// Shared definitions for the sdpram and its port-b read controller.
//   addr_t / data_t : default-width address and data words of the sdpram
//   MaxReadLatency  : largest read latency the controller supports
package sdpram_pkg;

  localparam int unsigned DefAddrBusWidth = 5;
  localparam int unsigned DefDataBusWidth = 8;
  localparam int unsigned MaxReadLatency  = 3;

  typedef logic [DefAddrBusWidth-1:0] addr_t;
  typedef logic [DefDataBusWidth-1:0] data_t;

endpackage

// File: rtl/sdpram_rd_ctrl_if.sv
// Request/response channel between a read consumer and sdpram_rd_ctrl.
//   req_valid/req_ready/req_addr : read request (consumer -> controller)
//   rsp_valid/rsp_ready/rsp_data : read result  (controller -> consumer)
// master = consumer side, slave = controller side.
interface sdpram_rd_ctrl_if #(
  parameter int unsigned AddrBusWidth = 5,
  parameter int unsigned DataBusWidth = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic [AddrBusWidth-1:0] req_addr;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DataBusWidth-1:0] rsp_data;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sdpram_rd_ctrl_sync_fifo.sv
// Circular skid FIFO holding returned read data until the consumer takes it.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write push_data_i at the tail
//   pop_i        : drop the head entry (ignored when empty)
//   data_o       : head entry (zero after reset)
//   empty_o/full_o : occupancy flags
module sync_fifo #(
  parameter int unsigned Depth        = 3,
  parameter int unsigned DataBusWidth = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [DataBusWidth-1:0] push_data_i,
  input  logic                    pop_i,
  output logic [DataBusWidth-1:0] data_o,
  output logic                    empty_o,
  output logic                    full_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [DataBusWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]         count_q, count_d;
  logic                    do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CntW'(push_i) - CntW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end
endmodule

// File: rtl/sdpram_rd_ctrl.sv
// Port-b read controller for one sdpram instance.
//   clk, rst           : clock, asynchronous active-low reset
//   rd (slave)         : request/response channel to the consumer
//   mem_addr, mem_re   : combinational passthrough to sdpram addr_b / re_b
//   mem_rdata          : sdpram r_data_b, sampled only when a read lands
//   busy               : a read is in flight or buffered
// Credits (pipeline occupancy + FIFO count) bound outstanding reads to
// Depth, so the skid FIFO can never overflow under backpressure.
module sdpram_rd_ctrl
  import sdpram_pkg::*;
#(
  parameter int unsigned AddrBusWidth = 5,
  parameter int unsigned DataBusWidth = 8,
  parameter int unsigned ReadLatency  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  sdpram_rd_ctrl_if.slave         rd,
  output logic [AddrBusWidth-1:0] mem_addr,
  output logic                    mem_re,
  input  logic [DataBusWidth-1:0] mem_rdata,
  output logic                    busy
);
  localparam int unsigned Depth     = ReadLatency + 2;
  // Data is sampled ReadLatency edges after the accept edge, which is one
  // stage beyond a ReadLatency-deep chain loaded at the accept edge.
  localparam int unsigned PipeDepth = ReadLatency + 1;
  localparam int unsigned UsedW     = $clog2(Depth + 1);

  logic [PipeDepth-1:0] pipe_q, pipe_d;
  logic [UsedW-1:0]     used_q, used_d;
  logic                 accept, pop, land;
  logic                 fifo_empty, fifo_full;

  assign pop          = rd.rsp_valid && rd.rsp_ready;
  // A pop in this cycle frees a credit immediately (rsp_ready -> req_ready).
  assign rd.req_ready = rst && ((used_q < UsedW'(Depth)) || pop);
  assign accept       = rd.req_valid && rd.req_ready;
  assign mem_re       = accept;
  assign mem_addr     = rd.req_addr;
  assign land         = pipe_q[PipeDepth-1];
  assign rd.rsp_valid = !fifo_empty;
  assign busy         = (used_q != '0);

  always_comb begin
    pipe_d = {pipe_q[PipeDepth-2:0], accept};
    used_d = used_q + UsedW'(accept) - UsedW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q <= '0;
      used_q <= '0;
    end else begin
      pipe_q <= pipe_d;
      used_q <= used_d;
    end
  end

  sync_fifo #(
    .Depth        (Depth),
    .DataBusWidth (DataBusWidth)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (land),
    .push_data_i (mem_rdata),
    .pop_i       (pop),
    .data_o      (rd.rsp_data),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  a_latency_range : assert property (@(posedge clk) disable iff (!rst)
    (ReadLatency >= 1) && (ReadLatency <= MaxReadLatency));

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(land && fifo_full));
endmodule

// File: tb/tb_sdpram_rd_ctrl.sv
module tb_sdpram_rd_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [4:0] req_addr;
  logic       rsp_ready;

  logic [2:0]      req_ready_w, rsp_valid_w, mem_re_w, busy_w;
  logic [2:0][7:0] rsp_data_w;
  logic [2:0][4:0] mem_addr_w;

  logic [7:0] mem_arr [32];

  logic [7:0] sb_data [3][64];
  int sb_wr [3];
  int sb_rd [3];
  int acc_cnt [3];
  int base [3];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc;

  always #5 clk = ~clk;

  // Three controllers, ReadLatency 1..3, sharing one stimulus stream.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned RL = g + 1;
    sdpram_rd_ctrl_if #(.AddrBusWidth(5), .DataBusWidth(8)) rif ();
    logic [4:0] m_addr;
    logic       m_re, m_busy;
    logic [7:0] m_rdata;
    logic [7:0] st_d [4];
    logic [3:0] st_v = '0;

    assign rif.req_valid   = req_valid;
    assign rif.req_addr    = req_addr;
    assign rif.rsp_ready   = rsp_ready;
    assign req_ready_w[g]  = rif.req_ready;
    assign rsp_valid_w[g]  = rif.rsp_valid;
    assign rsp_data_w[g]   = rif.rsp_data;
    assign mem_re_w[g]     = m_re;
    assign mem_addr_w[g]   = m_addr;
    assign busy_w[g]       = m_busy;

    // Memory model: data valid only in the cycle after edge RL past the
    // accept edge, poison value otherwise.
    always @(posedge clk) begin
      st_v    <= {st_v[2:0], m_re};
      st_d[0] <= mem_arr[m_addr];
      for (int k = 1; k < 4; k++) st_d[k] <= st_d[k-1];
    end
    assign m_rdata = st_v[RL] ? st_d[RL] : 8'hEE;

    sdpram_rd_ctrl #(
      .AddrBusWidth (5),
      .DataBusWidth (8),
      .ReadLatency  (RL)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .rd        (rif),
      .mem_addr  (m_addr),
      .mem_re    (m_re),
      .mem_rdata (m_rdata),
      .busy      (m_busy)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample handshakes mid-cycle, update scoreboards, then advance past the edge.
  task automatic tick();
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      if (!rst) begin
        sb_wr[j] = 0;
        sb_rd[j] = 0;
      end else begin
        if (rsp_valid_w[j] && rsp_ready) begin
          chk($sformatf("sb_pending%0d", j), 32'(sb_wr[j] != sb_rd[j]), 32'd1);
          chk($sformatf("sb_data%0d", j), 32'(rsp_data_w[j]), 32'(sb_data[j][sb_rd[j] % 64]));
          sb_rd[j]++;
        end
        if (req_valid && req_ready_w[j]) begin
          sb_data[j][sb_wr[j] % 64] = mem_arr[req_addr];
          sb_wr[j]++;
          acc_cnt[j]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int j = 0; j < 3; j++) begin
      sb_wr[j] = 0; sb_rd[j] = 0; acc_cnt[j] = 0;
    end
    rst = 1'b0; req_valid = 1'b1; req_addr = 5'h00; rsp_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem_arr[i] = 8'(i) ^ 8'hA5;
    mem_arr[5'h1B] = 8'hC5;  // port a write
    tick(); tick();

    // Reset state, with req_valid held high
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("rst_req_ready%0d", j), 32'(req_ready_w[j]), 0);
      chk($sformatf("rst_mem_re%0d", j), 32'(mem_re_w[j]), 0);
      chk($sformatf("rst_rsp_valid%0d", j), 32'(rsp_valid_w[j]), 0);
      chk($sformatf("rst_rsp_data%0d", j), 32'(rsp_data_w[j]), 0);
      chk($sformatf("rst_busy%0d", j), 32'(busy_w[j]), 0);
    end
    req_valid = 1'b0; rst = 1'b1; #1;
    for (int j = 0; j < 3; j++)
      chk($sformatf("rel_req_ready%0d", j), 32'(req_ready_w[j]), 1);

    // Single read of 0x1B, latency sweep across RL=1..3
    req_valid = 1'b1; req_addr = 5'h1B; rsp_ready = 1'b1; #1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("single_mem_re%0d", j), 32'(mem_re_w[j]), 1);
      chk($sformatf("single_mem_addr%0d", j), 32'(mem_addr_w[j]), 32'h1B);
    end
    tick();
    req_valid = 1'b0; #1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("single_re_pulse%0d", j), 32'(mem_re_w[j]), 0);
      chk($sformatf("single_busy%0d", j), 32'(busy_w[j]), 1);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("single_valid%0d_e%0d", j, k), 32'(rsp_valid_w[j]), 32'(k == j + 2));
        if (k == j + 2) chk($sformatf("single_data%0d", j), 32'(rsp_data_w[j]), 32'hC5);
      end
    end
    for (int j = 0; j < 3; j++)
      chk($sformatf("single_idle%0d", j), 32'(busy_w[j]), 0);

    // Back-to-back: 16 requests, one response per cycle
    for (int t = 0; t <= 20; t++) begin
      req_valid = (t < 16); req_addr = 5'(t); rsp_ready = 1'b1; #1;
      for (int j = 0; j < 3; j++) begin
        int i;
        i = t - (j + 1) - 2;
        if (t < 16) chk($sformatf("b2b_req_ready%0d_t%0d", j, t), 32'(req_ready_w[j]), 1);
        chk($sformatf("b2b_valid%0d_t%0d", j, t), 32'(rsp_valid_w[j]), 32'(i >= 0 && i < 16));
        if (i >= 0 && i < 16)
          chk($sformatf("b2b_data%0d_t%0d", j, t), 32'(rsp_data_w[j]), 32'(8'(i) ^ 8'hA5));
      end
      tick();
    end

    // Backpressure: exactly Depth accepted, then drain in order
    rsp_ready = 1'b0;
    for (int j = 0; j < 3; j++) base[j] = acc_cnt[j];
    for (int t = 0; t < 10; t++) begin
      req_valid = 1'b1; req_addr = 5'(5'h10 + t);
      tick();
    end
    req_valid = 1'b0; #1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("bp_accepted%0d", j), 32'(acc_cnt[j] - base[j]), 32'(j + 3));
      chk($sformatf("bp_req_ready%0d", j), 32'(req_ready_w[j]), 0);
      chk($sformatf("bp_busy%0d", j), 32'(busy_w[j]), 1);
      chk($sformatf("bp_valid%0d", j), 32'(rsp_valid_w[j]), 1);
      chk($sformatf("bp_head%0d", j), 32'(rsp_data_w[j]), 32'(8'h10 ^ 8'hA5));
    end
    rsp_ready = 1'b1; #1;
    for (int j = 0; j < 3; j++)
      chk($sformatf("bp_ready_on_pop%0d", j), 32'(req_ready_w[j]), 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("bp_drain_valid%0d_k%0d", j, k), 32'(rsp_valid_w[j]), 32'(k < j + 3));
        if (k < j + 3)
          chk($sformatf("bp_drain_data%0d_k%0d", j, k), 32'(rsp_data_w[j]),
              32'(8'(8'h10 + k) ^ 8'hA5));
      end
    end

    // Reset mid-stream with two reads in flight
    req_valid = 1'b1; req_addr = 5'h1B; tick();
    req_addr = 5'h00; tick();
    req_valid = 1'b0; rst = 1'b0; #1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("mid_rst_valid%0d", j), 32'(rsp_valid_w[j]), 0);
      chk($sformatf("mid_rst_busy%0d", j), 32'(busy_w[j]), 0);
      chk($sformatf("mid_rst_req_ready%0d", j), 32'(req_ready_w[j]), 0);
    end
    tick(); tick();
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      for (int j = 0; j < 3; j++)
        chk($sformatf("no_stale%0d_k%0d", j, k), 32'(rsp_valid_w[j]), 0);
    end
    for (int j = 0; j < 3; j++)
      chk($sformatf("post_rst_busy%0d", j), 32'(busy_w[j]), 0);

    // Random rsp_ready, at least 200 accepted requests per controller
    for (int i = 0; i < 32; i++) mem_arr[i] = 8'($urandom);
    for (int j = 0; j < 3; j++) base[j] = acc_cnt[j];
    cyc = 0;
    while (cyc < 3000 && !((acc_cnt[0] - base[0] >= 200) && (acc_cnt[1] - base[1] >= 200) &&
                           (acc_cnt[2] - base[2] >= 200))) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = 5'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (12) tick();
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("rand_enough%0d", j), 32'(acc_cnt[j] - base[j] >= 200), 1);
      chk($sformatf("rand_drained%0d", j), 32'(sb_wr[j] - sb_rd[j]), 0);
      chk($sformatf("rand_busy%0d", j), 32'(busy_w[j]), 0);
      chk($sformatf("rand_valid%0d", j), 32'(rsp_valid_w[j]), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
